// File: rtl/aoc7_pkg.sv
// aoc7_pkg: shared constants and types for the AoC day-7 stream driver.
//   ASCII_* : grid bytes with special meaning to the driver
//   drv_state_t : driver FSM states
//   DEF_*   : default parameter values for the driver and its accumulator
package aoc7_pkg;

    localparam logic [7:0] ASCII_NL    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPLIT = 8'h5E;

    localparam int DEF_LINE_LENGTH = 141;
    localparam int DEF_SUM_WIDTH   = 64;
    localparam int DEF_DATA_WIDTH  = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } drv_state_t;

endpackage

// File: rtl/aoc7_stream_driver_if.sv
// aoc7_stream_driver_if: byte-stream handshake between a byte source and the driver.
//   char_in    : ASCII byte
//   char_valid : char_in valid
//   char_last  : final byte of the grid (qualified by char_valid)
//   char_ready : byte accepted when char_valid && char_ready
// master = byte source, slave = stream driver.
interface aoc7_stream_driver_if;

    logic [7:0] char_in;
    logic       char_valid;
    logic       char_last;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        output char_last,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        input  char_last,
        output char_ready
    );

endinterface

// File: rtl/aoc7_stream_driver_drain_accumulator.sv
// drain_accumulator: issues LINE_LENGTH consecutive drain strobes after start and adds
// count_in on every edge where one of its strobes is on the wire.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the sum and counters (new run)
//   start        : begin a drain sequence
//   count_in     : per-column count presented while a strobe is on the wire
//   issue        : a strobe should be driven next cycle (registered by the caller)
//   done         : this edge performs the final add
//   sum          : running sum, modulo 2^SUM_WIDTH
module drain_accumulator #(
    parameter int LINE_LENGTH = 141,
    parameter int DATA_WIDTH  = 64,
    parameter int SUM_WIDTH   = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] count_in,
    output logic                  issue,
    output logic                  done,
    output logic [SUM_WIDTH-1:0]  sum
);

    localparam int CNT_W = $clog2(LINE_LENGTH + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LINE_LENGTH);

    logic                 busy_r;
    logic                 strobe_r;   // mirrors the caller's registered en during drain
    logic [CNT_W-1:0]     issued_r;
    logic [SUM_WIDTH-1:0] sum_r;
    logic                 issue_s;
    logic                 done_s;

    // Strobe request and final-add detection.
    always_comb begin
        issue_s = 1'b0;
        done_s  = 1'b0;
        if (busy_r) begin
            issue_s = (issued_r != LEN_C);
            done_s  = strobe_r && (issued_r == LEN_C);
        end else begin
            issue_s = 1'b0;
            done_s  = 1'b0;
        end
    end

    // Strobe counter and zero-extending accumulator.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            busy_r   <= 1'b0;
            strobe_r <= 1'b0;
            issued_r <= '0;
            sum_r    <= '0;
        end else if (start) begin
            busy_r   <= 1'b1;
            strobe_r <= 1'b0;
            issued_r <= '0;
        end else if (busy_r) begin
            strobe_r <= issue_s;
            if (issue_s) begin
                issued_r <= issued_r + CNT_W'(1);
            end
            if (strobe_r) begin
                sum_r <= sum_r + SUM_WIDTH'(count_in);
            end
            if (done_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign issue = issue_s;
    assign done  = done_s;
    assign sum   = sum_r;

endmodule

// File: rtl/aoc7_stream_driver.sv
// aoc7_stream_driver: converts a grid byte stream into the splitter's en/split_in column
// stream, then drains LINE_LENGTH count_out words into a SUM_WIDTH-bit answer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : begin a run (honoured in IDLE/DONE only)
//   byte_if      : byte stream (slave side)
//   en, split_in : registered column strobe / '^' flag to the splitter
//   count_out    : per-column count from the splitter
//   sum_out      : accumulated answer, valid while sum_valid
//   sum_valid    : high in DONE
//   line_err     : sticky, some line had a column count other than LINE_LENGTH
module aoc7_stream_driver
    import aoc7_pkg::*;
#(
    parameter int LINE_LENGTH = DEF_LINE_LENGTH,
    parameter int SUM_WIDTH   = DEF_SUM_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    aoc7_stream_driver_if.slave     byte_if,
    output logic                    en,
    output logic                    split_in,
    input  logic [DATA_WIDTH-1:0]   count_out,
    output logic [SUM_WIDTH-1:0]    sum_out,
    output logic                    sum_valid,
    output logic                    line_err
);

    // Column counter saturates one past a legal line so overflow stays visible.
    localparam int COL_W = $clog2(LINE_LENGTH + 2);
    localparam logic [COL_W-1:0] LEN_C = COL_W'(LINE_LENGTH);
    localparam logic [COL_W-1:0] SAT_C = COL_W'(LINE_LENGTH + 1);

    drv_state_t       state_r;
    drv_state_t       state_nxt_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_nxt_s;
    logic             en_r;
    logic             split_r;
    logic             ready_r;
    logic             err_r;
    logic             valid_r;
    logic             accept_s;
    logic             run_start_s;
    logic             drain_start_s;
    logic             stream_en_s;
    logic             stream_split_s;
    logic             nl_err_s;
    logic             tail_err_s;
    logic             acc_issue_s;
    logic             acc_done_s;

    // Byte decode and column checking for the byte accepted this cycle.
    always_comb begin
        accept_s       = (state_r == STREAM) && byte_if.char_valid;
        run_start_s    = start && ((state_r == IDLE) || (state_r == DONE));
        drain_start_s  = accept_s && byte_if.char_last;
        col_nxt_s      = col_r;
        stream_en_s    = 1'b0;
        stream_split_s = 1'b0;
        nl_err_s       = 1'b0;
        tail_err_s     = 1'b0;
        if (accept_s) begin
            case (byte_if.char_in)
                ASCII_NL: begin
                    nl_err_s  = (col_r != LEN_C);
                    col_nxt_s = '0;
                end
                ASCII_CR: begin
                    col_nxt_s = col_r;
                end
                default: begin
                    stream_en_s    = 1'b1;
                    stream_split_s = (byte_if.char_in == ASCII_SPLIT);
                    col_nxt_s      = (col_r == SAT_C) ? col_r : (col_r + COL_W'(1));
                end
            endcase
            // An unterminated final line is judged on the count it reached.
            tail_err_s = byte_if.char_last && (col_nxt_s != '0) && (col_nxt_s != LEN_C);
        end else begin
            col_nxt_s = col_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = start ? STREAM : IDLE;
            STREAM:  state_nxt_s = drain_start_s ? DRAIN : STREAM;
            DRAIN:   state_nxt_s = acc_done_s ? DONE : DRAIN;
            DONE:    state_nxt_s = start ? STREAM : DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, column counter and sticky line error.
    always_ff @(posedge clock) begin
        if (reset) begin
            en_r    <= 1'b0;
            split_r <= 1'b0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            col_r   <= '0;
        end else begin
            en_r    <= (state_r == DRAIN) ? acc_issue_s : stream_en_s;
            split_r <= (state_r == DRAIN) ? 1'b0 : stream_split_s;
            ready_r <= (state_nxt_s == STREAM);
            valid_r <= (state_nxt_s == DONE);
            if (run_start_s) begin
                col_r <= '0;
                err_r <= 1'b0;
            end else begin
                col_r <= col_nxt_s;
                if (nl_err_s || tail_err_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    drain_accumulator #(
        .LINE_LENGTH (LINE_LENGTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SUM_WIDTH   (SUM_WIDTH)
    ) u_drain (
        .clock    (clock),
        .reset    (reset),
        .clear    (run_start_s),
        .start    (drain_start_s),
        .count_in (count_out),
        .issue    (acc_issue_s),
        .done     (acc_done_s),
        .sum      (sum_out)
    );

    assign en                 = en_r;
    assign split_in           = split_r;
    assign sum_valid          = valid_r;
    assign line_err           = err_r;
    assign byte_if.char_ready = ready_r;

endmodule

// File: tb/tb_aoc7_stream_driver.sv
// tb_aoc7_stream_driver: scoreboard bench for aoc7_stream_driver with LINE_LENGTH=3.
// Stimulus pushes expected column strobes and run results into queues; a monitor on the
// falling edge pops them whenever en or a sum_valid rise appears, and acts as a stub
// splitter by presenting the planned drain values on count_out.
module tb_aoc7_stream_driver;
    import aoc7_pkg::*;

    localparam int L  = 3;
    localparam int DW = 12;
    localparam int SW = 13;

    typedef struct {
        bit split;
        bit drain;
    } strobe_t;

    typedef struct {
        int sum;
        bit err;
    } result_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          en;
    logic          split_in;
    logic [DW-1:0] count_out;
    logic [SW-1:0] sum_out;
    logic          sum_valid;
    logic          line_err;

    aoc7_stream_driver_if bif();

    aoc7_stream_driver #(
        .LINE_LENGTH (L),
        .SUM_WIDTH   (SW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .byte_if   (bif),
        .en        (en),
        .split_in  (split_in),
        .count_out (count_out),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .line_err  (line_err)
    );

    always #5 clock = ~clock;

    strobe_t exp_q[$];
    result_t res_q[$];
    int      drain_vals[$];
    int      vals_cfg[L];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      last_drain_cyc = -100;
    bit      prev_sv = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: every terminated line and a nonempty unterminated tail must hold L columns.
    function automatic bit model_err(input string txt);
        int len = 0;
        bit err = 1'b0;
        for (int i = 0; i < txt.len(); i++) begin
            if (txt[i] == ASCII_NL) begin
                if (len != L) err = 1'b1;
                len = 0;
            end else if (txt[i] != ASCII_CR) begin
                len++;
            end
        end
        if (len != 0 && len != L) err = 1'b1;
        return err;
    endfunction

    // Monitor and stub splitter.
    initial begin
        strobe_t e;
        result_t r;
        count_out = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_sv = 1'b0;
            end else begin
                count_out = DW'($urandom);
                if (en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_strobe: en=1 split_in=%0b expected no strobe", split_in);
                    end else begin
                        e = exp_q.pop_front();
                        check("split_in", split_in, e.split);
                        if (e.drain) begin
                            count_out = (drain_vals.size() > 0) ? DW'(drain_vals.pop_front()) : '0;
                            last_drain_cyc = cyc;
                        end
                    end
                end
                if (sum_valid && !prev_sv) begin
                    if (res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: sum_valid=1 expected 0");
                    end else begin
                        r = res_q.pop_front();
                        check("sum_out", sum_out, r.sum);
                        check("line_err", line_err, r.err);
                        check("done_latency", cyc - last_drain_cyc, 1);
                        check("strobes_left", exp_q.size(), 0);
                    end
                end
                prev_sv = sum_valid;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", bif.char_ready, 1);
        check("start_sum_clr", sum_out, 0);
        check("start_err_clr", line_err, 0);
        check("start_valid_clr", sum_valid, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        bit ok = 1'b0;
        strobe_t e;
        bif.char_valid = 1'b0;
        repeat (gap) tick();
        bif.char_in    = b;
        bif.char_valid = 1'b1;
        bif.char_last  = last;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = bif.char_ready;
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: char_ready=0 expected 1");
        end else begin
            if (b != ASCII_NL && b != ASCII_CR) begin
                e.split = (b == ASCII_SPLIT);
                e.drain = 1'b0;
                exp_q.push_back(e);
            end
            if (last) begin
                for (int i = 0; i < L; i++) begin
                    e.split = 1'b0;
                    e.drain = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end
        bif.char_valid = 1'b0;
        bif.char_last  = 1'b0;
    endtask

    // One full run; abort=1 resets the DUT once the drain has begun.
    task automatic run_grid(input string txt, input bit gapped, input bit rnd, input bit abort);
        int      s = 0;
        int      v;
        bit      ok = 1'b0;
        result_t r;
        do_start();
        drain_vals.delete();
        for (int i = 0; i < L; i++) begin
            v = rnd ? int'($urandom_range(0, 4095)) : vals_cfg[i];
            drain_vals.push_back(v);
            s += v;
        end
        r.sum = s % (1 << SW);
        r.err = model_err(txt);
        res_q.push_back(r);
        for (int i = 0; i < txt.len(); i++) begin
            send_byte(txt[i], i == txt.len() - 1, gapped ? 2 : 0);
        end
        if (abort) begin
            for (int k = 0; k < 50 && drain_vals.size() == L; k++) tick();
            reset = 1'b1;
            tick();
            check("rst_en", en, 0);
            check("rst_sum", sum_out, 0);
            check("rst_valid", sum_valid, 0);
            check("rst_ready", bif.char_ready, 0);
            reset = 1'b0;
            exp_q.delete();
            res_q.delete();
            drain_vals.delete();
        end else begin
            for (int k = 0; k < 100 && !ok; k++) begin
                if (sum_valid) ok = 1'b1;
                else tick();
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL done_timeout: sum_valid=0 expected 1");
            end
            tick();
            tick();
            check("hold_valid", sum_valid, 1);
            check("hold_sum", sum_out, r.sum);
            check("hold_err", line_err, r.err);
        end
    endtask

    initial begin
        string txt;
        reset = 1'b1;
        start = 1'b0;
        bif.char_in    = 8'h00;
        bif.char_valid = 1'b0;
        bif.char_last  = 1'b0;
        repeat (3) tick();
        check("reset_en", en, 0);
        check("reset_split", split_in, 0);
        check("reset_sum", sum_out, 0);
        check("reset_valid", sum_valid, 0);
        check("reset_err", line_err, 0);
        check("reset_ready", bif.char_ready, 0);
        reset = 1'b0;

        // Bytes offered in IDLE must not be consumed.
        bif.char_in    = ASCII_SPLIT;
        bif.char_valid = 1'b1;
        repeat (3) tick();
        check("idle_ready", bif.char_ready, 0);
        bif.char_valid = 1'b0;

        vals_cfg = '{1, 2, 3};
        run_grid(".^.\n...\n", 1'b0, 1'b0, 1'b0);
        run_grid(".^.\r\n^.^\r\n", 1'b1, 1'b1, 1'b0);
        run_grid("..\n...\n", 1'b0, 1'b1, 1'b0);
        run_grid(".^^", 1'b0, 1'b1, 1'b0);
        run_grid("^^^\n..", 1'b1, 1'b1, 1'b0);
        run_grid("....\n^^^\n", 1'b0, 1'b1, 1'b0);
        run_grid("^.^\n\r", 1'b0, 1'b1, 1'b0);

        vals_cfg = '{4095, 4095, 4095};
        run_grid("^^^\n", 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            txt = "";
            for (int ln = 0; ln < 3; ln++) begin
                for (int c = 0; c < (($urandom_range(0, 5) == 0) ? L - 1 : L); c++) begin
                    txt = {txt, ($urandom_range(0, 1) == 1) ? "^" : "."};
                end
                if (ln < 2 || $urandom_range(0, 1) == 1) begin
                    txt = {txt, ($urandom_range(0, 1) == 1) ? "\r\n" : "\n"};
                end
            end
            run_grid(txt, n[0], 1'b1, 1'b0);
        end

        vals_cfg = '{100, 200, 300};
        run_grid(".^.\n^^^\n", 1'b0, 1'b0, 1'b0);
        run_grid(".^.\n^^^\n", 1'b0, 1'b0, 1'b1);
        run_grid(".^.\n^^^\n", 1'b0, 1'b0, 1'b0);

        check("results_left", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
